// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the multicycle HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int MD_DATA_W = 32;
  localparam int MD_CNT_W  = 5;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } md_state_e;

  localparam logic [MD_DATA_W-1:0] LO_DIVZ = 32'hFFFFFFFF;

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step on a {hi,lo} pair.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int W = MD_DATA_W
) (
  input  logic         is_div,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] opnd_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [W:0] sum;
  logic [W:0] acc;
  logic [W:0] rsh;
  logic [W:0] diff;

  always_comb begin
    sum  = {1'b0, hi_i} + {1'b0, opnd_i};
    acc  = lo_i[0] ? sum : {1'b0, hi_i};
    // Remainder stays below the divisor, so the shifted value fits W+1 bits and
    // a set top bit of the difference means the trial subtract went negative.
    rsh  = {hi_i, lo_i[W-1]};
    diff = rsh - {1'b0, opnd_i};
    if (is_div) begin
      hi_o = diff[W] ? rsh[W-1:0] : diff[W-1:0];
      lo_o = {lo_i[W-2:0], ~diff[W]};
    end else begin
      hi_o = acc[W:1];
      lo_o = {acc[0], lo_i[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO owner: 32-step iterative multiply/divide with sign fixup, MTHI/MTLO writes and pipeline stall.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MD_DATA_W,
  parameter int CNT_W  = MD_CNT_W
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              iStart,
  input  logic [2:0]        iOp,
  input  logic [DATA_W-1:0] iA,
  input  logic [DATA_W-1:0] iB,
  input  logic              iReadHi,
  input  logic              iReadLo,
  output logic [DATA_W-1:0] oHI,
  output logic [DATA_W-1:0] oLO,
  output logic              oBusy,
  output logic              oStall,
  output logic              oDone,
  output logic              oDivZero
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] opnd_q, opnd_d, a_raw_q, a_raw_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic              done_q, done_d, divz_q, divz_d;

  logic              is_sgn, a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag, step_hi, step_lo;
  logic [2*DATA_W-1:0] prod;

  muldiv_iter #(.W(DATA_W)) u_iter (
    .is_div (state_q == S_DIV),
    .hi_i   (acc_hi_q),
    .lo_i   (acc_lo_q),
    .opnd_i (opnd_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  always_comb begin
    is_sgn = (iOp == MD_MULT) || (iOp == MD_DIV);
    a_neg  = is_sgn & iA[DATA_W-1];
    b_neg  = is_sgn & iB[DATA_W-1];
    a_mag  = a_neg ? (~iA + 1'b1) : iA;
    b_mag  = b_neg ? (~iB + 1'b1) : iB;
    prod   = {acc_hi_q, acc_lo_q};
    if (neg_q) prod = ~prod + 1'b1;

    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divz_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          case (iOp)
            MD_MTHI: hi_d = iA;
            MD_MTLO: lo_d = iA;
            MD_MULT, MD_MULTU: begin
              state_d   = S_MUL;
              acc_hi_d  = '0;
              acc_lo_d  = b_mag;
              opnd_d    = a_mag;
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              state_d   = S_DIV;
              acc_hi_d  = '0;
              acc_lo_d  = a_mag;
              opnd_d    = b_mag;
              neg_d     = a_neg ^ b_neg;
              rem_neg_d = a_neg;
            end
            default: ;
          endcase
          if (iOp <= MD_DIVU) begin
            cnt_d   = '0;
            op_d    = iOp;
            a_raw_d = iA;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == {CNT_W{1'b1}}) state_d = S_FIX;
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if ((op_q == MD_DIV) || (op_q == MD_DIVU)) begin
          if (opnd_q == '0) begin
            lo_d   = DATA_W'(LO_DIVZ);
            hi_d   = a_raw_q;
            divz_d = 1'b1;
          end else begin
            lo_d = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
            hi_d = rem_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
          end
        end else begin
          hi_d = prod[2*DATA_W-1:DATA_W];
          lo_d = prod[DATA_W-1:0];
        end
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divz_q    <= divz_d;
    end
  end

  assign oHI      = hi_q;
  assign oLO      = lo_q;
  assign oBusy    = (state_q != S_IDLE);
  assign oStall   = oBusy & (iStart | iReadHi | iReadLo);
  assign oDone    = done_q;
  assign oDivZero = divz_q;

endmodule
